// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller: opcodes, FSM states
// and the hex-to-7-segment table ({a,b,c,d,e,f,g}, a in bit 6).
package seg_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Entry N sits at [N]; the list below runs from F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit value to 7-segment pattern lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[val_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Request-driven 4-bit ALU feeding a digit buffer that is scanned onto a
// multiplexed 7-segment display. Optional: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_a,
  input  logic [3:0]                    req_b,
  input  logic [1:0]                    req_op,
  input  logic [$clog2(NUM_DIGITS)-1:0] req_digit,
  input  logic                          disp_en,
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         digit_sel
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  function automatic logic [3:0] alu_fn(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [1:0] op);
    logic [3:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_OR:   r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic                    accept;
  logic [3:0]              a_q, b_q;
  logic [1:0]              op_q;
  logic [DIG_W-1:0]        dig_q;
  logic                    wr_en;
  logic [3:0]              wr_val;
  logic [3:0]              buf_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   written_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        scan_q, scan_d;
  logic [3:0]              cur_val;
  logic                    cur_wr;
  logic                    blank;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  // Request FSM
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= req_a;
      b_q   <= req_b;
      op_q  <= req_op;
      dig_q <= req_digit;
    end
  end

  // Execute and buffer write; out-of-range targets execute but drop the write
  assign wr_en  = (state_q == ST_EXEC) && (32'(dig_q) < NUM_DIGITS);
  assign wr_val = alu_fn(a_q, b_q, op_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= 4'h0;
      written_q <= '0;
    end else if (wr_en) begin
      buf_q[dig_q]     <= wr_val;
      written_q[dig_q] <= 1'b1;
    end
  end

  // Scanner
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    scan_d = scan_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d  = '0;
      scan_d = (scan_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      scan_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
    end
  end

  assign cur_val = buf_q[scan_q];
  assign cur_wr  = written_q[scan_q];

  seg_hex_decode u_dec (
    .val_i (cur_val),
    .seg_o (dec_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Blank while this and every higher digit hold zero or are unwritten
  always_comb begin
    blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(scan_q)) && written_q[i] && (buf_q[i] != 4'h0)) blank = 1'b0;
    end
    if ((scan_q == '0) && cur_wr) blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  // Output register
  always_comb begin
    seg_d = '0;
    sel_d = '0;
    if (disp_en) begin
      sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_q;
      if (cur_wr && !blank) seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      sel_q <= '0;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg_out   = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencing controller for the 4-bit ALU plus hex 7-segment datapath.
- Accepts operation requests over a valid/ready handshake and executes one ALU op per request (add/sub/or/xor).
- Stores each 4-bit result in a per-digit buffer.
- Time-multiplexes the buffer onto a single 7-segment bus with one-hot digit selects for a multi-digit display.

Parameters:
- NUM_DIGITS, 4, number of display digits / buffer entries (2..8).
- REFRESH_DIV, 1000, clk cycles each digit is held before the scanner advances (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_a  input  4  operand A.
- req_b  input  4  operand B.
- req_op  input  2  opcode: 00 add, 10 sub, 01 or, 11 xor.
- req_digit  input  $clog2(NUM_DIGITS)  target buffer entry.
- disp_en  input  1  display enable; low blanks the display.
- seg_out  output  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-high, registered.
- digit_sel  output  NUM_DIGITS  one-hot active-high digit enable, registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FSM goes to IDLE, req_ready=1.
  - All digit buffers cleared and marked unwritten.
  - Scan index=0, refresh counter=0.
  - seg_out=0, digit_sel=0.
- FSM states: IDLE and EXEC.
  - IDLE: req_ready=1. On req_valid&req_ready, capture a, b, op, digit into registers; next state is EXEC.
  - EXEC: req_ready=0. Compute result from the captured operands and write it to buf[digit] with written[digit]=1; next state is IDLE.
  - Throughput: one request per 2 cycles.
  - req_valid held high is accepted again on the next IDLE cycle.
- Arithmetic is modulo 16: add = (a+b)[3:0], sub = (a-b)[3:0] two's complement wrap, or = a|b, xor = a^b.
- Out-of-range req_digit (>= NUM_DIGITS): request is accepted and EXEC occurs, but no buffer write.
- Scanner:
  - Refresh counter counts 0..REFRESH_DIV-1, free-running regardless of disp_en.
  - At terminal count it wraps to 0 and the scan index advances, wrapping NUM_DIGITS-1 -> 0.
- Output register, updated every cycle:
  - disp_en=1: digit_sel = one-hot(scan index); seg_out = hex decode of buf[scan index] if written, else 0000000.
  - disp_en=0: seg_out=0, digit_sel=0.
- Hex decode table, values 0..F:
  - 1111110, 0110000, 1101101, 1111001
  - 0110011, 1011011, 1011111, 1110000
  - 1111111, 1111011, 1110111, 0011111
  - 1001110, 0111101, 1001111, 1000111
- Latency: the EXEC write is visible on seg_out one cycle after the EXEC edge, if that digit is currently scanned; otherwise when it is next scanned.
- Simultaneous write to the displayed digit and scan advance: the output register uses the pre-write buffer value that cycle and the new value the next cycle. No glitch beyond one cycle.
- Reset mid-EXEC: the write is aborted and the buffer is cleared.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit is blanked (seg_out=0, digit_sel still asserted) if its buffer value is 0 (or it is unwritten) and every higher-index digit is also 0 or unwritten. Digit 0 is never blanked when written.
- Undefined: written zero digits always display 1111110.

Decomposition:
- Package seg_pkg holds:
  - opcode localparams OP_ADD=2'b00, OP_OR=2'b01, OP_SUB=2'b10, OP_XOR=2'b11;
  - state encoding ST_IDLE / ST_EXEC;
  - the 16-entry segment constant table.
- Sub-module: seg_hex_decode, combinational 4-bit value -> 7-bit segment pattern, instantiated once on the scan-selected digit.

Test Plan (bench uses REFRESH_DIV=4, NUM_DIGITS=4):
- Reset -> seg_out=0, digit_sel=0 held during reset; req_ready=1 the cycle after reset is released.
- Request a=4'h9, b=4'h8, op=00, digit=0 with disp_en=1 -> result 4'h1. When digit_sel=0001, seg_out=0110000. req_ready=0 for exactly one cycle.
- Request a=3, b=5, op=10, digit=2 -> result 4'hE; digit_sel=0100 shows 1001111. Digits 1 and 3, unwritten, show 0000000.
- Back-to-back requests with req_valid held high: op=01 (a=4'hA, b=4'h5) to digit 1, then op=11 (a=4'hF, b=4'hF) to digit 3 -> digit 1 shows F=1000111, digit 3 shows 0=1111110 (blank with SEG_LEADING_ZERO_BLANK_EN). Accepts are 2 cycles apart.
- Scan sequence over 32 cycles -> digit_sel 0001, 0010, 0100, 1000, 0001 …, each held 4 cycles. Toggle disp_en low -> seg_out=0 and digit_sel=0 the next cycle, while scan timing continues.
- Assert rst during EXEC of a write to digit 0 -> digit 0 reads unwritten (seg_out=0 when scanned) after reset.
